// File: rtl/counter_load_ctrl_pkg.sv
// Shared constants and FSM state encoding for the counter load sequencer.
package counter_load_ctrl_pkg;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned LAP_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2,
      ST_PAUSE = 2'd3
   } state_t;

endpackage

// File: rtl/counter_load_ctrl_if.sv
// Host command / status bundle between a host (master) and the sequencer (slave).
interface counter_load_ctrl_if;
   import counter_load_ctrl_pkg::*;

   logic             start;
   logic             stop;
   logic             pause;
   logic [CNT_W-1:0] start_val;
   logic [CNT_W-1:0] end_val;
   logic [CNT_W-1:0] q;
   logic             busy;
   logic             paused;
   logic             done;
   logic [LAP_W-1:0] laps;

   modport master (
      output start, stop, pause, start_val, end_val,
      input  q, busy, paused, done, laps
   );

   modport slave (
      input  start, stop, pause, start_val, end_val,
      output q, busy, paused, done, laps
   );

endinterface

// File: rtl/counter_4bit_with_load.sv
// 4-bit up-counter with synchronous load; load takes priority over enable.
module counter_4bit_with_load
   import counter_load_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] d,
   output logic [CNT_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst)       q <= '0;
      else if (load) q <= d;
      else if (en)   q <= q + CNT_W'(1);
   end

endmodule

// File: rtl/counter_load_ctrl.sv
// Sequencer driving a loadable counter through load/count/terminal with pause and stop.
// Optional feature macro: CTRL_AUTORELOAD_EN (gapless reload at terminal, lap counting).
module counter_load_ctrl
   import counter_load_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   counter_load_ctrl_if.slave bus
);

   state_t           state;
   logic [CNT_W-1:0] start_reg;
   logic [CNT_W-1:0] end_reg;
   logic [CNT_W-1:0] q;
   logic             busy_r;
   logic             paused_r;
   logic             done_r;
   logic             cnt_en_c;
   logic             cnt_load_c;
   logic             terminal_c;

   // Counter control; stop always wins, terminal beats pause.
   always_comb begin
      cnt_en_c   = 1'b0;
      cnt_load_c = 1'b0;
      terminal_c = (state == ST_RUN) && (q == end_reg);
      case (state)
         ST_LOAD: cnt_load_c = !bus.stop;
         ST_RUN: begin
            if (!bus.stop) begin
               if (terminal_c) begin
`ifdef CTRL_AUTORELOAD_EN
                  cnt_load_c = 1'b1;
`endif
               end else if (!bus.pause) begin
                  cnt_en_c = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   counter_4bit_with_load u_cnt (
      .clk  (clk),
      .rst  (rst),
      .en   (cnt_en_c),
      .load (cnt_load_c),
      .d    (start_reg),
      .q    (q)
   );

`ifdef CTRL_AUTORELOAD_EN
   logic [LAP_W-1:0] laps_r;

   always_ff @(posedge clk) begin
      if (rst)                                    laps_r <= '0;
      else if (terminal_c && !bus.stop)           laps_r <= laps_r + LAP_W'(1);
   end

   assign bus.laps = laps_r;
`else
   assign bus.laps = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         start_reg <= '0;
         end_reg   <= '0;
         busy_r    <= 1'b0;
         paused_r  <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start && !bus.stop) begin
                  start_reg <= bus.start_val;
                  end_reg   <= bus.end_val;
                  state     <= ST_LOAD;
                  busy_r    <= 1'b1;
               end
            end
            ST_LOAD: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
               end else begin
                  state  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.stop) begin
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
               end else if (terminal_c) begin
                  done_r <= 1'b1;
`ifndef CTRL_AUTORELOAD_EN
                  state  <= ST_IDLE;
                  busy_r <= 1'b0;
`endif
               end else if (bus.pause) begin
                  state    <= ST_PAUSE;
                  paused_r <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (bus.stop) begin
                  state    <= ST_IDLE;
                  busy_r   <= 1'b0;
                  paused_r <= 1'b0;
               end else if (!bus.pause) begin
                  state    <= ST_RUN;
                  paused_r <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.q      = q;
   assign bus.busy   = busy_r;
   assign bus.paused = paused_r;
   assign bus.done   = done_r;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Self-checking bench for counter_load_ctrl (one-shot build, or CTRL_AUTORELOAD_EN build).
module tb_counter_load_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   counter_load_ctrl_if bif ();

   counter_load_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   typedef struct {
      logic       rst;
      logic       start;
      logic       stop;
      logic       pause;
      logic [3:0] sv;
      logic [3:0] ev;
      logic [3:0] q;
      logic       busy;
      logic       paused;
      logic       done;
      logic [7:0] laps;
   } vec_t;

   typedef struct {
      logic [3:0] q;
      logic       busy;
      logic       paused;
      logic       done;
      logic [7:0] laps;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   span_sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int idx, input int unsigned act,
                        input int unsigned exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic st, input logic sp, input logic pa,
                      input int sv, input int ev, input int q, input logic b,
                      input logic p, input logic d, input int laps);
      vec_t v;
      v.rst = r; v.start = st; v.stop = sp; v.pause = pa;
      v.sv = 4'(sv); v.ev = 4'(ev); v.q = 4'(q);
      v.busy = b; v.paused = p; v.done = d; v.laps = 8'(laps);
      vecs.push_back(v);
   endtask

   // Drive one cycle of stimulus, queue its expectation, compare after the edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t e;
      exp_t got;
      rst           = v.rst;
      bif.start     = v.start;
      bif.stop      = v.stop;
      bif.pause     = v.pause;
      bif.start_val = v.sv;
      bif.end_val   = v.ev;
      e.q = v.q; e.busy = v.busy; e.paused = v.paused; e.done = v.done; e.laps = v.laps;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard[%0d]: got empty queue, expected entry", idx);
      end else begin
         got = sb.pop_front();
         check("q",      idx, int'(bif.q),      int'(got.q));
         check("busy",   idx, int'(bif.busy),   int'(got.busy));
         check("paused", idx, int'(bif.paused), int'(got.paused));
         check("done",   idx, int'(bif.done),   int'(got.done));
         check("laps",   idx, int'(bif.laps),   int'(got.laps));
      end
   endtask

   task automatic run_vecs();
      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
      vecs.delete();
   endtask

   // Edges from the start edge until done: one for LOAD->RUN plus one per RUN cycle.
   task automatic span(input int sv, input int ev, input int idx);
      int edges;
      int run_cycles;
      run_cycles = (ev >= sv) ? (ev - sv + 1) : (ev + 16 - sv + 1);
      span_sb.push_back(run_cycles + 1);
      bif.start = 1'b1; bif.start_val = 4'(sv); bif.end_val = 4'(ev);
      @(posedge clk); #1;
      bif.start = 1'b0; bif.start_val = 4'(ev); bif.end_val = 4'(sv);
      edges = 0;
      while (!bif.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      if (!bif.done) begin
         checks++; errors++;
         $display("FAIL span_timeout[%0d]: got no done after %0d cycles, expected done", idx, edges);
         void'(span_sb.pop_front());
      end else begin
         check("span_edges", idx, edges, span_sb.pop_front());
         check("span_q", idx, int'(bif.q), ev);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      bif.start = 1'b0; bif.stop = 1'b0; bif.pause = 1'b0;
      bif.start_val = '0; bif.end_val = '0;
      #2;

      // reset for two cycles
      add(1,0,0,0, 0,0,  0,0,0,0, 0);
      add(1,0,0,0, 0,0,  0,0,0,0, 0);
      run_vecs();

`ifndef CTRL_AUTORELOAD_EN
      // 5 -> 9, with an ignored start mid-run
      add(0,1,0,0, 5,9,  0,1,0,0, 0);
      add(0,0,0,0, 0,0,  5,1,0,0, 0);
      add(0,1,0,0, 0,0,  6,1,0,0, 0);
      add(0,0,0,0, 0,0,  7,1,0,0, 0);
      add(0,0,0,0, 0,0,  8,1,0,0, 0);
      add(0,0,0,0, 0,0,  9,1,0,0, 0);
      add(0,0,0,0, 0,0,  9,0,0,1, 0);
      add(0,0,0,0, 0,0,  9,0,0,0, 0);
      // wrap 12 -> 2
      add(0,1,0,0, 12,2, 9,1,0,0, 0);
      add(0,0,0,0, 0,0, 12,1,0,0, 0);
      add(0,0,0,0, 0,0, 13,1,0,0, 0);
      add(0,0,0,0, 0,0, 14,1,0,0, 0);
      add(0,0,0,0, 0,0, 15,1,0,0, 0);
      add(0,0,0,0, 0,0,  0,1,0,0, 0);
      add(0,0,0,0, 0,0,  1,1,0,0, 0);
      add(0,0,0,0, 0,0,  2,1,0,0, 0);
      add(0,0,0,0, 0,0,  2,0,0,1, 0);
      add(0,0,0,0, 0,0,  2,0,0,0, 0);
      // pause at 7 for three cycles
      add(0,1,0,0, 5,9,  2,1,0,0, 0);
      add(0,0,0,0, 0,0,  5,1,0,0, 0);
      add(0,0,0,0, 0,0,  6,1,0,0, 0);
      add(0,0,0,0, 0,0,  7,1,0,0, 0);
      add(0,0,0,1, 0,0,  7,1,1,0, 0);
      add(0,0,0,1, 0,0,  7,1,1,0, 0);
      add(0,0,0,1, 0,0,  7,1,1,0, 0);
      add(0,0,0,0, 0,0,  7,1,0,0, 0);
      add(0,0,0,0, 0,0,  8,1,0,0, 0);
      add(0,0,0,0, 0,0,  9,1,0,0, 0);
      add(0,0,0,0, 0,0,  9,0,0,1, 0);
      add(0,0,0,0, 0,0,  9,0,0,0, 0);
      // stop with pause at 6, then start+stop in IDLE
      add(0,1,0,0, 5,9,  9,1,0,0, 0);
      add(0,0,0,0, 0,0,  5,1,0,0, 0);
      add(0,0,0,0, 0,0,  6,1,0,0, 0);
      add(0,0,1,1, 0,0,  6,0,0,0, 0);
      add(0,0,0,0, 0,0,  6,0,0,0, 0);
      add(0,1,1,0, 3,3,  6,0,0,0, 0);
      add(0,0,0,0, 0,0,  6,0,0,0, 0);
      // start == end
      add(0,1,0,0, 4,4,  6,1,0,0, 0);
      add(0,0,0,0, 0,0,  4,1,0,0, 0);
      add(0,0,0,0, 0,0,  4,0,0,1, 0);
      add(0,0,0,0, 0,0,  4,0,0,0, 0);
      // stop while paused
      add(0,1,0,0, 0,3,  4,1,0,0, 0);
      add(0,0,0,0, 0,0,  0,1,0,0, 0);
      add(0,0,0,1, 0,0,  0,1,1,0, 0);
      add(0,0,1,1, 0,0,  0,0,0,0, 0);
      // stop during LOAD: no load happens
      add(0,1,0,0, 10,11, 0,1,0,0, 0);
      add(0,0,1,0, 0,0,   0,0,0,0, 0);
      // terminal beats pause
      add(0,1,0,0, 1,2,  0,1,0,0, 0);
      add(0,0,0,0, 0,0,  1,1,0,0, 0);
      add(0,0,0,0, 0,0,  2,1,0,0, 0);
      add(0,0,0,1, 0,0,  2,0,0,1, 0);
      add(0,0,0,0, 0,0,  2,0,0,0, 0);
      // reset mid-sequence
      add(0,1,0,0, 7,12, 2,1,0,0, 0);
      add(0,0,0,0, 0,0,  7,1,0,0, 0);
      add(0,0,0,0, 0,0,  8,1,0,0, 0);
      add(1,0,0,0, 0,0,  0,0,0,0, 0);
      add(0,0,0,0, 0,0,  0,0,0,0, 0);
      run_vecs();

      span(5, 9, 0);
      span(12, 2, 1);
      span(4, 4, 2);
      span(15, 0, 3);
      for (int k = 0; k < 4; k++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         span(a, b, 4 + k);
      end
`else
      // gapless reload 3..5, two laps then stop, then reset clears laps
      add(0,1,0,0, 3,5,  0,1,0,0, 0);
      add(0,0,0,0, 0,0,  3,1,0,0, 0);
      add(0,0,0,0, 0,0,  4,1,0,0, 0);
      add(0,0,0,0, 0,0,  5,1,0,0, 0);
      add(0,0,0,0, 0,0,  3,1,0,1, 1);
      add(0,0,0,0, 0,0,  4,1,0,0, 1);
      add(0,0,0,0, 0,0,  5,1,0,0, 1);
      add(0,0,0,0, 0,0,  3,1,0,1, 2);
      add(0,0,0,0, 0,0,  4,1,0,0, 2);
      add(0,0,1,0, 0,0,  4,0,0,0, 2);
      add(0,0,0,0, 0,0,  4,0,0,0, 2);
      add(1,0,0,0, 0,0,  0,0,0,0, 0);
      // start == end reloads every cycle
      add(0,1,0,0, 6,6,  0,1,0,0, 0);
      add(0,0,0,0, 0,0,  6,1,0,0, 0);
      add(0,0,0,0, 0,0,  6,1,0,1, 1);
      add(0,0,0,0, 0,0,  6,1,0,1, 2);
      add(0,0,1,0, 0,0,  6,0,0,0, 2);
      run_vecs();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
